// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_CPU = 1'b0;
    localparam req_id_t REQ_LDR = 1'b1;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and loader ports.
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise the CPU port
// always wins a tie and no last-winner input exists.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    req0_i,
    input  logic    req1_i,
`ifdef MEM_ARB_RR_EN
    input  req_id_t last_i,
`endif
    output req_id_t win_o,
    output logic    vld_o
);

    // Pick a winner; a tie goes to whichever port did not win last time
    // (round-robin) or to the CPU port (fixed priority).
    always_comb begin
        vld_o = req0_i | req1_i;
        win_o = REQ_CPU;
        if (req0_i && req1_i) begin
`ifdef MEM_ARB_RR_EN
            win_o = (last_i == REQ_CPU) ? REQ_LDR : REQ_CPU;
`else
            win_o = REQ_CPU;
`endif
        end else if (req1_i) begin
            win_o = REQ_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port unified memory.
// One access in flight at a time: IDLE grants, BUSY drives the memory for
// MEM_LAT cycles, RESP pulses done with the captured read data.
// Optional macro MEM_ARB_RR_EN: round-robin tie-breaking (default: CPU wins).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t       state_q;
    req_id_t          win_q;
    logic             we_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    rdata_q;
    logic             done0_q, done1_q;
    logic             mem_en_q, mem_we_q;

    req_id_t          pick_win;
    logic             pick_vld;
    logic             accept;
    logic             we_d;
    logic [AW-1:0]    addr_d;
    logic [DW-1:0]    wdata_d;

`ifdef MEM_ARB_RR_EN
    req_id_t          last_q;
`endif

    mem_arb_pick u_pick (
        .req0_i (req0),
        .req1_i (req1),
`ifdef MEM_ARB_RR_EN
        .last_i (last_q),
`endif
        .win_o  (pick_win),
        .vld_o  (pick_vld)
    );

    // Grant only from IDLE; suppressed while reset is asserted so every
    // output reads 0 during reset.
    always_comb begin
        accept  = (state_q == IDLE) && pick_vld && !reset;
        we_d    = (pick_win == REQ_LDR) ? we1    : we0;
        addr_d  = (pick_win == REQ_LDR) ? addr1  : addr0;
        wdata_d = (pick_win == REQ_LDR) ? wdata1 : wdata0;
    end

    assign gnt0      = accept && (pick_win == REQ_CPU);
    assign gnt1      = accept && (pick_win == REQ_LDR);
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Access sequencer: latch the winner, count out the latency, pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            win_q    <= REQ_CPU;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        win_q    <= pick_win;
                        we_q     <= we_d;
                        addr_q   <= addr_d;
                        wdata_q  <= wdata_d;
                        cnt_q    <= CNT_LOAD;
                        mem_en_q <= 1'b1;
                        // Write strobe only in the first BUSY cycle.
                        mem_we_q <= we_d;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        if (!we_q) rdata_q <= mem_rdata;
                        mem_en_q <= 1'b0;
                        done0_q  <= (win_q == REQ_CPU);
                        done1_q  <= (win_q == REQ_LDR);
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember every grant's winner; reset to the loader so the CPU takes
    // the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       last_q <= REQ_LDR;
        else if (accept) last_q <= pick_win;
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the multicycle core's single-port unified memory. Requester 0 is the CPU memory port (fetch, load and store). Requester 1 is the program loader/debug port. The block accepts one access at a time, drives the memory for a fixed `MEM_LAT` cycles, and returns a one-cycle completion pulse with read data to the winner. It sits between the multicycle datapath's memory interface and the memory macro.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `MEM_LAT`, 2, memory access latency in cycles; legal range 1..15.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `req0` / `req1`  in  1  access request; held until the matching `gnt` is seen.
- `we0` / `we1`  in  1  1 = write, 0 = read; valid while `req` is high.
- `addr0` / `addr1`  in  `AW`  access address.
- `wdata0` / `wdata1`  in  `DW`  write data.
- `gnt0` / `gnt1`  out  1  combinational acceptance pulse, IDLE state only.
- `done0` / `done1`  out  1  one-cycle completion pulse, for reads and writes.
- `rdata`  out  `DW`  read data; valid while `done*` is high after a read.
- `mem_en`  out  1  memory access enable.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  `AW`  latched address.
- `mem_wdata`  out  `DW`  latched write data.
- `mem_rdata`  in  `DW`  memory read data; valid in the last BUSY cycle.

## Operation
- States are IDLE, BUSY and RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If any request is pending, select a winner and assert its `gnt` in the same cycle.
  - At the clock edge, latch the winner id, `we`, `addr` and `wdata`, load the latency counter with `MEM_LAT-1`, and go to BUSY.
- BUSY:
  - `mem_en` = 1; `mem_addr` and `mem_wdata` come from the latches.
  - `mem_we` = 1 only in the first BUSY cycle of a write.
  - The counter decrements each cycle.
  - When the counter is 0: for a read, capture `mem_rdata` into the `rdata` register; then go to RESP.
- RESP:
  - `done` of the latched winner = 1; `rdata` is held.
  - Go to IDLE next cycle.
  - No grant is issued in RESP.
- Arbitration with a single requester: that requester wins.
- Arbitration with both requesting: see Configuration.
- `req` dropped before `gnt`: no access is made and no state changes.
- `rdata` holds its last captured value until the next read completes. A write leaves `rdata` unchanged.

## Timing
- A request is accepted in cycle T (`gnt` high in T).
- BUSY occupies T+1 .. T+`MEM_LAT`.
- `done` is high in T+`MEM_LAT`+1.
- The earliest next grant is in T+`MEM_LAT`+2.
- Maximum throughput is one access per `MEM_LAT`+2 cycles.
- `MEM_LAT`=1 gives a single BUSY cycle, which carries both the `mem_we` strobe and the read capture.
- Reset values: state IDLE; all outputs 0, including `rdata`, `mem_*`, `gnt*` and `done*`; last-winner register = 1.
- Reset mid-access (in BUSY or RESP): the access is aborted, `mem_en` drops at the asynchronous assertion, and no `done` pulse is issued.
- `gnt0` and `gnt1` are never high in the same cycle.
- `done0` and `done1` are never high in the same cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, grant the requester that was not the last winner.
  - The last-winner register updates on every grant.
  - After reset, requester 0 wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority.
  - Requester 0 always wins a tie.
  - The last-winner register is not built.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, BUSY, RESP);
  - the requester id typedef `req_id_t` (1 bit);
  - the constants `REQ_CPU` = 0 and `REQ_LDR` = 1.
- Sub-module `mem_arb_pick` is purely combinational. It takes `req0`, `req1` and the last winner, and produces the winner id and a valid flag. The `MEM_ARB_RR_EN` selection lives inside it.
- The top level holds the FSM, the latency counter and the request latches.

## Test plan
- Single read: `MEM_LAT`=2, `req0`=1, `we0`=0, `addr0`=0x40, memory returns 0xDEADBEEF → `gnt0` high at T, `mem_en` high T+1..T+2, `done0` high at T+3, `rdata`=0xDEADBEEF.
- Single write: `req1`=1, `we1`=1, `addr1`=0x100, `wdata1`=0x1234 → `mem_we` high only in T+1, `mem_addr`=0x100, `done1` high at T+3, `rdata` unchanged.
- Continuous contention, both requesting reads:
  - With `MEM_ARB_RR_EN`: grant order 0,1,0,1, each grant 4 cycles apart.
  - Without it: grant order 0,0,0,0.
- Latency sweep, `MEM_LAT`=1 and `MEM_LAT`=15 → `done` exactly `MEM_LAT`+1 cycles after `gnt`; `mem_we` is a single cycle in both cases.
- Reset during BUSY, asserted at T+1 of a read → all outputs 0 immediately, no `done` pulse; after release, a new `req0` is granted normally.
- Request withdrawn: `req1` pulsed for one cycle during RESP of a `req0` access → no `gnt1` and no memory access.
